// File: rtl/rr_arb_sched.sv
// rr_arb_sched: round-robin arbiter/scheduler for one multi-cycle shared
// resource. A winner holds the grant until it releases; the rotating pointer
// then sits on the last winner so everyone above it is preferred next.
// Optional feature macro: RR_ARB_SCHED_TIMEOUT_EN (bounded ownership with a
// forced release and an o_timeout pulse). Without it ownership is unbounded.

// mask: thermometer mask relative to a one-hot pointer.
// TOWARDS_LSB=0 selects bits above ptr, TOWARDS_LSB=1 bits below ptr;
// INCLUSIVE adds the ptr bit itself.
module mask #(
    parameter int W           = 4,
    parameter bit TOWARDS_LSB = 1'b0,
    parameter bit INCLUSIVE   = 1'b0
) (
    input  logic [W-1:0] ptr,
    output logic [W-1:0] msk
);
    localparam logic [W-1:0] ONE = W'(1);

    // For a one-hot ptr, (ptr-1) is the run of ones below it; the shifted
    // form folds the ptr bit in. Overflow of ptr<<1 at the MSB yields an
    // empty "above" mask, which is exactly the wrap-around case.
    generate
        if (!TOWARDS_LSB && !INCLUSIVE) begin : g_up_excl
            assign msk = ~((ptr << 1) - ONE);
        end else if (!TOWARDS_LSB && INCLUSIVE) begin : g_up_incl
            assign msk = ~(ptr - ONE);
        end else if (TOWARDS_LSB && !INCLUSIVE) begin : g_dn_excl
            assign msk = ptr - ONE;
        end else begin : g_dn_incl
            assign msk = (ptr << 1) - ONE;
        end
    endgenerate
endmodule

module rr_arb_sched #(
    parameter int N       = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic [N-1:0]         i_req,
    input  logic                 i_rel,
    output logic [N-1:0]         o_gnt,
    output logic                 o_gnt_vld,
    output logic [$clog2(N)-1:0] o_gnt_id,
    output logic                 o_timeout
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT);

    generate
        if (N < 2 || TIMEOUT < 2) begin : g_bad_param
            $error("rr_arb_sched: N and TIMEOUT must both be >= 2");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    ptr, ptr_nxt;
    logic [N-1:0]    gnt, gnt_nxt;
    logic            gnt_vld, gnt_vld_nxt;
    logic [IW-1:0]   gnt_id, gnt_id_nxt;
    logic            tmo, tmo_nxt;

    logic [N-1:0]    above;
    logic [N-1:0]    m_req;
    logic [N-1:0]    pick_src;
    logic [N-1:0]    win;
    logic [IW-1:0]   win_id;
    logic            any_req;
    logic            force_rel;
    logic            release_now;
    logic            issue;

    // Bits strictly above the pointer; ptr always names the last winner.
    mask #(
        .W           (N),
        .TOWARDS_LSB (1'b0),
        .INCLUSIVE   (1'b0)
    ) u_mask (
        .ptr (ptr),
        .msk (above)
    );

    assign any_req  = |i_req;
    assign m_req    = i_req & above;
    assign pick_src = (m_req != '0) ? m_req : i_req;
    // Lowest set bit; an empty request vector gives zero.
    assign win      = pick_src & (~pick_src + N'(1));

    // Binary index of the one-hot winner.
    always_comb begin
        win_id = '0;
        for (int i = 0; i < N; i++) begin
            if (win[i]) begin
                win_id = IW'(i);
            end
        end
    end

`ifdef RR_ARB_SCHED_TIMEOUT_EN
    logic [CW-1:0] own_cnt;

    assign force_rel = (state == BUSY) && !i_rel && (own_cnt == CW'(TIMEOUT - 1));

    // Ownership age: cleared on every grant issue, counts BUSY cycles, 0 in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            own_cnt <= '0;
        end else if (issue || state_nxt == IDLE) begin
            own_cnt <= '0;
        end else begin
            own_cnt <= own_cnt + CW'(1);
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    assign release_now = (state == BUSY) && (i_rel || force_rel);
    assign issue       = i_en && any_req && ((state == IDLE) || release_now);

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        gnt_nxt     = gnt;
        gnt_vld_nxt = gnt_vld;
        gnt_id_nxt  = gnt_id;
        tmo_nxt     = force_rel;
        if (issue) begin
            state_nxt   = BUSY;
            ptr_nxt     = win;
            gnt_nxt     = win;
            gnt_vld_nxt = 1'b1;
            gnt_id_nxt  = win_id;
        end else if (release_now) begin
            state_nxt   = IDLE;
            gnt_nxt     = '0;
            gnt_vld_nxt = 1'b0;
            gnt_id_nxt  = '0;
        end
    end

    // State and grant registers; reset parks ptr on the MSB so bit 0 wins first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= {1'b1, {(N-1){1'b0}}};
            gnt     <= '0;
            gnt_vld <= 1'b0;
            gnt_id  <= '0;
            tmo     <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt     <= gnt_nxt;
            gnt_vld <= gnt_vld_nxt;
            gnt_id  <= gnt_id_nxt;
            tmo     <= tmo_nxt;
        end
    end

    assign o_gnt     = gnt;
    assign o_gnt_vld = gnt_vld;
    assign o_gnt_id  = gnt_id;
`ifdef RR_ARB_SCHED_TIMEOUT_EN
    assign o_timeout = tmo;
`else
    assign o_timeout = 1'b0;
`endif

`ifndef SYNTHESIS
    // Grant must be one-hot or empty, and the valid/id outputs must agree with it.
    always @(posedge clk) begin
        assert ($onehot0(gnt)) else $error("rr_arb_sched: grant not one-hot");
        assert (gnt_vld == (|gnt)) else $error("rr_arb_sched: gnt_vld inconsistent");
    end
`endif
endmodule

// File: tb/tb_rr_arb_sched.sv
// Directed table-driven bench for rr_arb_sched (N=4, TIMEOUT=8).
module tb_rr_arb_sched;
    localparam int N  = 4;
    localparam int TO = 8;

    logic         clk;
    logic         rst_n;
    logic         i_en;
    logic [N-1:0] i_req;
    logic         i_rel;
    logic [N-1:0] o_gnt;
    logic         o_gnt_vld;
    logic [1:0]   o_gnt_id;
    logic         o_timeout;

    int total;
    int bad;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [3:0] req;
        logic       rel;
        logic [3:0] gnt;
        logic       vld;
        logic [1:0] id;
    } vec_t;

    vec_t tbl[64];
    int   nv;

    rr_arb_sched #(.N(N), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (i_en),
        .i_req     (i_req),
        .i_rel     (i_rel),
        .o_gnt     (o_gnt),
        .o_gnt_vld (o_gnt_vld),
        .o_gnt_id  (o_gnt_id),
        .o_timeout (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic [3:0] q, input logic l,
                       input logic [3:0] g, input logic [1:0] id);
        tbl[nv].rst_n = r;
        tbl[nv].en    = e;
        tbl[nv].req   = q;
        tbl[nv].rel   = l;
        tbl[nv].gnt   = g;
        tbl[nv].vld   = (g != 4'b0000);
        tbl[nv].id    = id;
        nv++;
    endtask

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, step, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [3:0] q, input logic l);
        @(negedge clk);
        rst_n = r;
        i_en  = e;
        i_req = q;
        i_rel = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nv    = 0;
        rst_n = 1'b0;
        i_en  = 1'b0;
        i_req = '0;
        i_rel = 1'b0;

        // rst en req rel -> gnt id
        add(0, 0, 4'b0000, 0, 4'b0000, 0);   // reset
        // full round with rel three cycles into each ownership
        add(1, 1, 4'b1111, 0, 4'b0001, 0);
        add(1, 1, 4'b1111, 0, 4'b0001, 0);
        add(1, 1, 4'b1111, 0, 4'b0001, 0);
        add(1, 1, 4'b1111, 1, 4'b0010, 1);
        add(1, 1, 4'b1111, 0, 4'b0010, 1);
        add(1, 1, 4'b1111, 0, 4'b0010, 1);
        add(1, 1, 4'b1111, 1, 4'b0100, 2);
        add(1, 1, 4'b1111, 0, 4'b0100, 2);
        add(1, 1, 4'b1111, 0, 4'b0100, 2);
        add(1, 1, 4'b1111, 1, 4'b1000, 3);
        add(1, 1, 4'b1111, 0, 4'b1000, 3);
        add(1, 1, 4'b1111, 0, 4'b1000, 3);
        add(1, 1, 4'b1111, 1, 4'b0001, 0);   // wrap back to 0
        // sole requester 2 is re-granted after its own release
        add(1, 1, 4'b0100, 1, 4'b0100, 2);
        add(1, 1, 4'b0100, 1, 4'b0100, 2);
        add(1, 1, 4'b0100, 0, 4'b0100, 2);
        add(1, 1, 4'b1111, 1, 4'b1000, 3);   // ptr stayed at bit 2
        // owner 1, then wrap to LSB with req 0011
        add(1, 1, 4'b0010, 1, 4'b0010, 1);
        add(1, 1, 4'b0011, 1, 4'b0001, 0);
        // i_en low while owner 2 holds, then release
        add(1, 1, 4'b0100, 1, 4'b0100, 2);
        add(1, 0, 4'b1111, 0, 4'b0100, 2);
        add(1, 0, 4'b1111, 1, 4'b0000, 0);
        add(1, 0, 4'b1111, 0, 4'b0000, 0);
        add(1, 1, 4'b1111, 0, 4'b1000, 3);
        // reset during ownership of 3
        add(0, 1, 4'b1111, 0, 4'b0000, 0);
        add(1, 1, 4'b1111, 0, 4'b0001, 0);
        // release with no request, rel in IDLE ignored
        add(1, 1, 4'b0000, 1, 4'b0000, 0);
        add(1, 1, 4'b0000, 1, 4'b0000, 0);
        add(1, 1, 4'b0001, 1, 4'b0001, 0);
        add(1, 1, 4'b0001, 0, 4'b0001, 0);
        // owner drops req but grant is held
        add(1, 1, 4'b0000, 0, 4'b0001, 0);

        for (int k = 0; k < nv; k++) begin
            drive(tbl[k].rst_n, tbl[k].en, tbl[k].req, tbl[k].rel);
            chk("gnt", k, 32'(o_gnt), 32'(tbl[k].gnt));
            chk("gnt_vld", k, 32'(o_gnt_vld), 32'(tbl[k].vld));
            chk("gnt_id", k, 32'(o_gnt_id), 32'(tbl[k].id));
            chk("timeout", k, 32'(o_timeout), 32'(1'b0));
        end

        // Owner 0 never releases while 0 and 1 request.
        drive(0, 1, 4'b0011, 0);
        chk("rst_gnt", 0, 32'(o_gnt), 32'(4'b0000));
        drive(1, 1, 4'b0011, 0);
        chk("first_gnt", 0, 32'(o_gnt), 32'(4'b0001));
`ifdef RR_ARB_SCHED_TIMEOUT_EN
        for (int c = 1; c < TO; c++) begin
            drive(1, 1, 4'b0011, 0);
            chk("hold_gnt", c, 32'(o_gnt), 32'(4'b0001));
            chk("hold_to", c, 32'(o_timeout), 32'(1'b0));
        end
        drive(1, 1, 4'b0011, 0);
        chk("forced_gnt", TO, 32'(o_gnt), 32'(4'b0010));
        chk("forced_id", TO, 32'(o_gnt_id), 32'(2'd1));
        chk("forced_to", TO, 32'(o_timeout), 32'(1'b1));
        drive(1, 1, 4'b0011, 0);
        chk("after_gnt", TO + 1, 32'(o_gnt), 32'(4'b0010));
        chk("after_to", TO + 1, 32'(o_timeout), 32'(1'b0));
`else
        for (int c = 1; c <= 100; c++) begin
            drive(1, 1, 4'b0011, 0);
            chk("hold_gnt", c, 32'(o_gnt), 32'(4'b0001));
            chk("hold_to", c, 32'(o_timeout), 32'(1'b0));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_arb_sched.md
Name: rr_arb_sched

Overview:
- Round-robin arbiter and scheduler sharing one multi-cycle resource (bus port, table write port) among N requesters.
- The winner owns the resource until it signals release; the rotating priority pointer then advances past the winner.
- Priority masking is built from the common `mask` block (one instance, TOWARDS_LSB=0, INCLUSIVE=0) plus a lowest-set-bit pick.
- Sits between requester front-ends and the shared resource's mux select.

Parameters:
- N, 4, number of requesters (>=2).
- TIMEOUT, 256, maximum ownership cycles before forced release (>=2; used only with the optional feature).

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- i_en  input  1  arbitration enable. When low, no new grant is issued; an existing grant is unaffected.
- i_req  input  N  per-requester request, level-sensitive.
- i_rel  input  1  release strobe from the current owner; meaningful only while o_gnt_vld=1.
- o_gnt  output  N  one-hot grant, registered.
- o_gnt_vld  output  1  OR of o_gnt, registered.
- o_gnt_id  output  $clog2(N)  binary index of o_gnt, registered. Value is 0 when o_gnt_vld=0.
- o_timeout  output  1  single-cycle pulse on a forced release; constant 0 without the optional feature.

Behaviour:
- State machine has two states: IDLE and BUSY. Reset gives state=IDLE, o_gnt=0, o_gnt_vld=0, o_gnt_id=0, o_timeout=0, ptr=one-hot bit N-1, so requester 0 has top priority first.
- Winner function W(req):
  - m = req & mask(ptr), i.e. bits strictly above ptr.
  - If m != 0, W = lowest set bit of m.
  - Otherwise W = lowest set bit of req.
  - If req == 0, W = 0.
- IDLE:
  - If i_en && |i_req, next cycle: o_gnt=W(i_req), state=BUSY, ptr=W(i_req).
  - Latency: request sampled at cycle t gives grant at t+1.
- BUSY:
  - The grant is held while i_rel=0, even if the owner drops i_req.
  - A new owner never preempts.
- Release (i_rel=1 in BUSY, or forced release):
  - If i_en && |i_req: next cycle o_gnt=W(i_req), evaluated with the already-updated ptr (the current owner). This is a zero-bubble handoff.
  - The releasing owner's own i_req is eligible but has lowest priority.
  - Re-granting the same owner is allowed only when it is the sole requester.
  - If there is no eligible request, or i_en=0: o_gnt=0, state=IDLE.
- i_rel while IDLE is ignored.
- ptr updates only on a grant issue. It holds through IDLE and i_en=0 periods.
- Wrap-around: with ptr=bit N-1, m=0, so selection restarts from bit 0.
- Simultaneous i_rel and i_en falling in the same cycle: the release completes, no new grant is issued, state goes to IDLE.
- rst_n low mid-ownership: all state returns to reset values at the next edge. Grant drops with no handoff.
- Invariant: o_gnt is one-hot or zero at all times. Assertion required under simulation.

Optional Feature:
- Macro: RR_ARB_SCHED_TIMEOUT_EN.
- When defined:
  - Ownership counter width is $clog2(TIMEOUT). It clears on every grant issue and increments each BUSY cycle.
  - When the counter equals TIMEOUT-1 and i_rel=0, that cycle is treated as a release.
  - o_timeout pulses high for the one cycle in which the new grant (or IDLE) takes effect.
  - The counter is held at 0 in IDLE.
- When undefined:
  - No counter is built.
  - o_timeout is tied to 0.
  - Ownership is unbounded.

Test Plan:
- Reset, then i_req=4'b1111 with i_en=1 and each owner pulsing i_rel 3 cycles after grant. Required grant sequence: 0001, 0010, 0100, 1000, 0001; zero idle cycles between grants.
- i_req=4'b0100 alone, release, i_req still 0100. Required: grant 0100 again one cycle after release; ptr stays at bit 2.
- ptr=bit 1 (owner 1 releases) with i_req=4'b0011. Required: grant 0001 (wrap to LSB), not 0010.
- i_en=0 while owner 2 is granted, then i_rel with i_req=1111. Required: o_gnt=0 and o_gnt_vld=0 next cycle; after i_en=1, grant 1000 one cycle later.
- rst_n=0 for one cycle during BUSY with owner 3. Required: all outputs 0 next cycle; first grant after reset with i_req=1111 is 0001.
- With RR_ARB_SCHED_TIMEOUT_EN and TIMEOUT=8, owner 0 never releases while i_req=0011. Required: o_timeout=1 and o_gnt=0010 exactly 8 cycles after the first grant; without the macro, grant 0001 persists for 100 cycles and o_timeout stays 0.
